// File: rtl/pes_elc_scan.sv
// pes_elc_scan -- multi-request SCAN elevator controller.
//
// Floor calls are latched into a pending bitmap and served in sweep order:
// the car keeps its direction while calls remain ahead of it, then reverses.
// Travel time per floor, door dwell, door obstruction and overload interlocks
// are modelled with a single shared down-counter.
//
// Optional feature macro: ELC_EMERGENCY_EN
//   When defined, adds `emergency` (in) and `emerg_active` (out). While
//   emergency is high, all calls are dropped, the car runs non-stop to floor 0
//   and holds the door open there. No completion pulse is issued. On release
//   the door finishes a normal dwell and operation resumes.
//
// Ports
//   clk               in   rising-edge clock
//   reset             in   synchronous, active-low reset
//   req_valid         in   floor call strobe
//   req_floor         in   called floor (ignored if >= N_FLOORS)
//   pos_load          in   force car position, honoured in IDLE only
//   in_current_floor  in   position for pos_load (ignored if >= N_FLOORS)
//   over_time         in   door obstruction sensor
//   over_weight       in   car overload sensor
//   out_current_floor out  current car floor
//   direction         out  1 = up, 0 = down
//   moving            out  car travelling
//   door_open         out  door open
//   complete          out  one-cycle pulse on arrival at a called floor
//   door_alert        out  door open while obstructed
//   weight_alert      out  door open while overloaded
//   pending           out  outstanding call bitmap
//
// State  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | parked, door closed; picks next target or sweep direction
// S_MOVE | travelling; counter counts cycles left before the next floor
// S_DOOR | door open; counter counts remaining dwell cycles

module pes_elc_scan #(
    parameter int N_FLOORS   = 8,
    parameter int FLOOR_W    = 3,
    parameter int TRAVEL_CYC = 4,
    parameter int DOOR_CYC   = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    input  logic [FLOOR_W-1:0]  req_floor,
    input  logic                pos_load,
    input  logic [FLOOR_W-1:0]  in_current_floor,
    input  logic                over_time,
    input  logic                over_weight,
`ifdef ELC_EMERGENCY_EN
    input  logic                emergency,
    output logic                emerg_active,
`endif
    output logic [FLOOR_W-1:0]  out_current_floor,
    output logic                direction,
    output logic                moving,
    output logic                door_open,
    output logic                complete,
    output logic                door_alert,
    output logic                weight_alert,
    output logic [N_FLOORS-1:0] pending
);

    localparam int CNT_MAX = (TRAVEL_CYC > DOOR_CYC) ? TRAVEL_CYC : DOOR_CYC;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0]    TRAV_RLD  = CNT_W'(TRAVEL_CYC - 1);
    localparam logic [CNT_W-1:0]    DOOR_RLD  = CNT_W'(DOOR_CYC - 1);
    localparam logic [FLOOR_W-1:0]  TOP_FLOOR = FLOOR_W'(N_FLOORS - 1);
    localparam logic [N_FLOORS-1:0] ONE_HOT0  = {{(N_FLOORS-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MOVE = 2'd1,
        S_DOOR = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [FLOOR_W-1:0]  floor_q, floor_d;
    logic                dir_q, dir_d;
    logic [N_FLOORS-1:0] pend_q, pend_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                complete_q, complete_d;
    logic                door_alert_q, door_alert_d;
    logic                weight_alert_q, weight_alert_d;
    logic                moving_q, door_q;
`ifdef ELC_EMERGENCY_EN
    logic                emerg_q, emerg_d;
`endif

    logic                req_ok;
    logic                load_ok;
    logic [FLOOR_W-1:0]  step_floor;
    logic [N_FLOORS-1:0] req_bit;
    logic [N_FLOORS-1:0] here_bit;
    logic [N_FLOORS-1:0] step_bit;

    // Any pending call strictly above (up=1) or below (up=0) floor f.
    function automatic logic calls_beyond(input logic [N_FLOORS-1:0] bm,
                                          input logic [FLOOR_W-1:0]  f,
                                          input logic                up);
        logic r;
        r = 1'b0;
        for (int i = 0; i < N_FLOORS; i++) begin
            if (up ? (i > int'(f)) : (i < int'(f))) begin
                r = r | bm[i];
            end
        end
        return r;
    endfunction

    assign req_ok   = req_valid && (int'(req_floor) < N_FLOORS);
    assign load_ok  = int'(in_current_floor) < N_FLOORS;
    assign req_bit  = ONE_HOT0 << req_floor;
    assign here_bit = ONE_HOT0 << floor_q;
    assign step_bit = ONE_HOT0 << step_floor;

    // Floor reached when the travel counter expires; clamped at both ends.
    always_comb begin
        step_floor = floor_q;
        if (dir_q) begin
            if (floor_q != TOP_FLOOR) step_floor = floor_q + 1'b1;
        end else begin
            if (floor_q != '0) step_floor = floor_q - 1'b1;
        end
    end

    always_comb begin
        state_d        = state_q;
        floor_d        = floor_q;
        dir_d          = dir_q;
        pend_d         = pend_q;
        cnt_d          = cnt_q;
        complete_d     = 1'b0;
        door_alert_d   = 1'b0;
        weight_alert_d = 1'b0;

        // A call to the floor whose door is open only extends the dwell.
        if (req_ok && !(state_q == S_DOOR && req_floor == floor_q)) begin
            pend_d = pend_d | req_bit;
        end

        case (state_q)
            S_IDLE: begin
                if (pos_load) begin
                    if (load_ok) floor_d = in_current_floor;
                end else if ((pend_q & here_bit) != '0) begin
                    // Clearing after the latch above makes a same-cycle call
                    // to this floor disappear rather than be served twice.
                    state_d    = S_DOOR;
                    pend_d     = pend_d & ~here_bit;
                    complete_d = 1'b1;
                    cnt_d      = DOOR_RLD;
                end else if (pend_q != '0) begin
                    if (!calls_beyond(pend_q, floor_q, dir_q)) dir_d = ~dir_q;
                    state_d = S_MOVE;
                    cnt_d   = TRAV_RLD;
                end
            end
            S_MOVE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    floor_d = step_floor;
                    if ((pend_q & step_bit) != '0) begin
                        state_d    = S_DOOR;
                        pend_d     = pend_d & ~step_bit;
                        complete_d = 1'b1;
                        cnt_d      = DOOR_RLD;
                    end else if (calls_beyond(pend_q, step_floor, dir_q)) begin
                        cnt_d = TRAV_RLD;
                    end else begin
                        // Nothing left ahead (only after an emergency flush).
                        state_d = S_IDLE;
                    end
                end
            end
            S_DOOR: begin
                door_alert_d   = over_time;
                weight_alert_d = over_weight;
                if (over_time || (req_ok && req_floor == floor_q)) begin
                    cnt_d = DOOR_RLD;
                end else if (over_weight) begin
                    cnt_d = cnt_q;
                end else if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef ELC_EMERGENCY_EN
        emerg_d = emergency;
        if (emergency) begin
            pend_d         = '0;
            complete_d     = 1'b0;
            dir_d          = 1'b0;
            door_alert_d   = 1'b0;
            weight_alert_d = 1'b0;
            if (state_q == S_MOVE && !dir_q && floor_q != '0) begin
                // Already heading down: finish the current hop without stopping.
                if (cnt_q != '0) begin
                    state_d = S_MOVE;
                    floor_d = floor_q;
                    cnt_d   = cnt_q - 1'b1;
                end else begin
                    floor_d = floor_q - 1'b1;
                    if (floor_q == FLOOR_W'(1)) begin
                        state_d = S_DOOR;
                        cnt_d   = DOOR_RLD;
                    end else begin
                        state_d = S_MOVE;
                        cnt_d   = TRAV_RLD;
                    end
                end
            end else if (floor_q == '0) begin
                // Hold the door: dwell keeps reloading until release.
                state_d        = S_DOOR;
                floor_d        = floor_q;
                cnt_d          = DOOR_RLD;
                door_alert_d   = (state_q == S_DOOR) && over_time;
                weight_alert_d = (state_q == S_DOOR) && over_weight;
            end else begin
                state_d = S_MOVE;
                floor_d = floor_q;
                cnt_d   = TRAV_RLD;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            floor_q        <= '0;
            dir_q          <= 1'b1;
            pend_q         <= '0;
            cnt_q          <= '0;
            complete_q     <= 1'b0;
            door_alert_q   <= 1'b0;
            weight_alert_q <= 1'b0;
            moving_q       <= 1'b0;
            door_q         <= 1'b0;
`ifdef ELC_EMERGENCY_EN
            emerg_q        <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            floor_q        <= floor_d;
            dir_q          <= dir_d;
            pend_q         <= pend_d;
            cnt_q          <= cnt_d;
            complete_q     <= complete_d;
            door_alert_q   <= door_alert_d;
            weight_alert_q <= weight_alert_d;
            moving_q       <= (state_d == S_MOVE);
            door_q         <= (state_d == S_DOOR);
`ifdef ELC_EMERGENCY_EN
            emerg_q        <= emerg_d;
`endif
        end
    end

    assign out_current_floor = floor_q;
    assign direction         = dir_q;
    assign moving            = moving_q;
    assign door_open         = door_q;
    assign complete          = complete_q;
    assign door_alert        = door_alert_q;
    assign weight_alert      = weight_alert_q;
    assign pending           = pend_q;
`ifdef ELC_EMERGENCY_EN
    assign emerg_active      = emerg_q;
`endif

endmodule

// File: tb/tb_pes_elc_scan.sv
// Testbench for pes_elc_scan: per-cycle reference model plus scenario checks.
module tb_pes_elc_scan;

    localparam int N  = 8;
    localparam int FW = 4;
    localparam int T  = 4;
    localparam int D  = 6;

    // {floor, dir, moving, door_open, complete, door_alert, weight_alert, pending}
    localparam logic [17:0] RST_VEC = {4'd0, 1'b1, 5'b00000, 8'h00};

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic [FW-1:0] req_floor;
    logic          pos_load;
    logic [FW-1:0] in_current_floor;
    logic          over_time;
    logic          over_weight;
    logic [FW-1:0] out_current_floor;
    logic          direction;
    logic          moving;
    logic          door_open;
    logic          complete;
    logic          door_alert;
    logic          weight_alert;
    logic [N-1:0]  pending;

    pes_elc_scan #(
        .N_FLOORS  (N),
        .FLOOR_W   (FW),
        .TRAVEL_CYC(T),
        .DOOR_CYC  (D)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_floor        (req_floor),
        .pos_load         (pos_load),
        .in_current_floor (in_current_floor),
        .over_time        (over_time),
        .over_weight      (over_weight),
        .out_current_floor(out_current_floor),
        .direction        (direction),
        .moving           (moving),
        .door_open        (door_open),
        .complete         (complete),
        .door_alert       (door_alert),
        .weight_alert     (weight_alert),
        .pending          (pending)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc_n       = 0;

    // Reference model: mode 0 parked, 1 travelling, 2 door open.
    // m_left counts cycles remaining until the next floor / door close.
    int     m_mode;
    int     m_floor;
    int     m_left;
    bit     m_dir;
    bit [7:0] m_pend;
    bit     m_comp;
    bit     m_dalert;
    bit     m_walert;

    function automatic bit beyond(bit [7:0] bm, int f, bit up);
        for (int i = 0; i < N; i++) begin
            if ((up && i > f) || (!up && i < f)) begin
                if (bm[i]) return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    function automatic void model_step();
        bit [7:0] old;
        bit [7:0] nw;
        int       rf;
        bit       req_here;
        if (!reset) begin
            m_mode = 0; m_floor = 0; m_dir = 1'b1; m_pend = 8'h00; m_left = 0;
            m_comp = 1'b0; m_dalert = 1'b0; m_walert = 1'b0;
            return;
        end
        old      = m_pend;
        nw       = old;
        rf       = int'(req_floor);
        req_here = req_valid && (rf == m_floor);
        m_comp   = 1'b0;
        m_dalert = (m_mode == 2) && over_time;
        m_walert = (m_mode == 2) && over_weight;
        if (req_valid && rf < N && !(m_mode == 2 && req_here)) nw[rf] = 1'b1;
        if (m_mode == 0) begin
            if (pos_load) begin
                if (int'(in_current_floor) < N) m_floor = int'(in_current_floor);
            end else if (old[m_floor]) begin
                m_mode = 2; m_left = D; m_comp = 1'b1; nw[m_floor] = 1'b0;
            end else if (old != 8'h00) begin
                if (!beyond(old, m_floor, m_dir)) m_dir = !m_dir;
                m_mode = 1; m_left = T;
            end
        end else if (m_mode == 1) begin
            m_left--;
            if (m_left == 0) begin
                if (m_dir) m_floor = (m_floor < N - 1) ? m_floor + 1 : m_floor;
                else       m_floor = (m_floor > 0) ? m_floor - 1 : m_floor;
                if (old[m_floor]) begin
                    m_mode = 2; m_left = D; m_comp = 1'b1; nw[m_floor] = 1'b0;
                end else if (beyond(old, m_floor, m_dir)) begin
                    m_left = T;
                end else begin
                    m_mode = 0;
                end
            end
        end else begin
            if (over_time || req_here) begin
                m_left = D;
            end else if (!over_weight) begin
                m_left--;
                if (m_left == 0) m_mode = 0;
            end
        end
        m_pend = nw;
    endfunction

    function automatic logic [17:0] obs();
        return {out_current_floor, direction, moving, door_open, complete,
                door_alert, weight_alert, pending};
    endfunction

    function automatic logic [17:0] exp_vec();
        return {4'(m_floor), m_dir, (m_mode == 1), (m_mode == 2), m_comp,
                m_dalert, m_walert, m_pend};
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    task automatic idle_inputs();
        req_valid = 1'b0; pos_load = 1'b0; over_time = 1'b0; over_weight = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            req_valid = 1'b1;
            req_floor = 4'($urandom_range(0, 7));
            tick();
            vectors++;
            if (obs() !== RST_VEC) begin
                miscompares++;
                $display("FAIL reset_state got=%h exp=%h", obs(), RST_VEC);
            end
        end
        reset = 1'b1;
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (obs() !== exp_vec()) begin
                miscompares++;
                $display("FAIL reset_idle got=%h exp=%h", obs(), exp_vec());
            end
        end
    endtask

    task automatic test_single_call();
        int comp_at  = -1;
        int door_cnt = 0;
        do_reset();
        req_valid = 1'b1; req_floor = 4'd3;
        tick();
        req_valid = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            vectors++;
            if (obs() !== exp_vec()) begin
                miscompares++;
                $display("FAIL single_model cyc=%0d got=%h exp=%h", i, obs(), exp_vec());
            end
            if (complete && comp_at < 0) comp_at = i;
            if (door_open) door_cnt++;
            if (i == T + 1 || i == 2 * T + 1) begin
                vectors++;
                if (int'(out_current_floor) != (i - 1) / T) begin
                    miscompares++;
                    $display("FAIL single_floor cyc=%0d got=%0d exp=%0d", i, out_current_floor, (i - 1) / T);
                end
            end
        end
        vectors++;
        if (comp_at != 3 * T + 1) begin
            miscompares++;
            $display("FAIL single_latency got=%0d exp=%0d", comp_at, 3 * T + 1);
        end
        vectors++;
        if (door_cnt != D) begin
            miscompares++;
            $display("FAIL single_door_len got=%0d exp=%0d", door_cnt, D);
        end
    endtask

    task automatic test_scan();
        int served[$];
        logic [7:0] pend_at[$];
        do_reset();
        pos_load = 1'b1; in_current_floor = 4'd2;
        tick();
        pos_load = 1'b0;
        req_valid = 1'b1; req_floor = 4'd5;
        tick();
        req_floor = 4'd0;
        tick();
        req_valid = 1'b0;
        vectors++;
        if (pending !== 8'h21) begin
            miscompares++;
            $display("FAIL scan_pending got=%h exp=21", pending);
        end
        for (int i = 0; i < 80; i++) begin
            tick();
            vectors++;
            if (obs() !== exp_vec()) begin
                miscompares++;
                $display("FAIL scan_model cyc=%0d got=%h exp=%h", i, obs(), exp_vec());
            end
            if (complete) begin
                served.push_back(int'(out_current_floor));
                pend_at.push_back(pending);
            end
        end
        vectors++;
        if (served.size() != 2 || pend_at.size() != 2) begin
            miscompares++;
            $display("FAIL scan_count got=%0d exp=2", served.size());
        end else if (served[0] != 5 || served[1] != 0 || pend_at[0] !== 8'h01 || pend_at[1] !== 8'h00) begin
            miscompares++;
            $display("FAIL scan_order got=%0d,%0d/%h,%h exp=5,0/01,00", served[0], served[1], pend_at[0], pend_at[1]);
        end
    endtask

    task automatic test_door_overtime();
        int alerts   = 0;
        int close_at = -1;
        do_reset();
        req_valid = 1'b1; req_floor = 4'd0;
        tick();
        req_valid = 1'b0;
        tick();
        vectors++;
        if (door_open !== 1'b1 || complete !== 1'b1) begin
            miscompares++;
            $display("FAIL ot_entry got=%b%b exp=11", door_open, complete);
        end
        tick();
        tick();
        over_time = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (obs() !== exp_vec()) begin
                miscompares++;
                $display("FAIL ot_model got=%h exp=%h", obs(), exp_vec());
            end
            if (door_alert) alerts++;
        end
        over_time = 1'b0;
        for (int j = 1; j <= 20; j++) begin
            tick();
            if (door_alert) alerts++;
            if (!door_open && close_at < 0) close_at = j;
        end
        vectors++;
        if (alerts != 3) begin
            miscompares++;
            $display("FAIL ot_alert_cnt got=%0d exp=3", alerts);
        end
        vectors++;
        if (close_at != D) begin
            miscompares++;
            $display("FAIL ot_close got=%0d exp=%0d", close_at, D);
        end
    endtask

    task automatic test_overweight();
        int alerts   = 0;
        int held     = 0;
        int close_at = -1;
        do_reset();
        req_valid = 1'b1; req_floor = 4'd0;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        tick();
        over_weight = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            vectors++;
            if (obs() !== exp_vec()) begin
                miscompares++;
                $display("FAIL ow_model got=%h exp=%h", obs(), exp_vec());
            end
            if (weight_alert) alerts++;
            if (door_open) held++;
        end
        over_weight = 1'b0;
        for (int j = 1; j <= 20; j++) begin
            tick();
            if (!door_open && close_at < 0) close_at = j;
        end
        vectors++;
        if (alerts != 10 || held != 10) begin
            miscompares++;
            $display("FAIL ow_hold got=%0d/%0d exp=10/10", alerts, held);
        end
        vectors++;
        if (close_at != D - 2) begin
            miscompares++;
            $display("FAIL ow_residual got=%0d exp=%0d", close_at, D - 2);
        end
    endtask

    task automatic test_ignored();
        do_reset();
        req_valid = 1'b1; req_floor = 4'd9;
        tick();
        req_valid = 1'b0;
        vectors++;
        if (pending !== 8'h00) begin
            miscompares++;
            $display("FAIL ign_range got=%h exp=00", pending);
        end
        pos_load = 1'b1; in_current_floor = 4'd12;
        tick();
        pos_load = 1'b0;
        vectors++;
        if (out_current_floor !== 4'd0) begin
            miscompares++;
            $display("FAIL ign_posload got=%0d exp=0", out_current_floor);
        end
        req_valid = 1'b1; req_floor = 4'd0;
        tick();
        req_valid = 1'b0;
        tick();
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        vectors++;
        if (pending !== 8'h00 || door_open !== 1'b1 || obs() !== exp_vec()) begin
            miscompares++;
            $display("FAIL ign_served got=%h exp=%h", obs(), exp_vec());
        end
        for (int i = 0; i < 20; i++) tick();
        req_valid = 1'b1; req_floor = 4'd6;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        vectors++;
        if (moving !== 1'b1 || out_current_floor !== 4'd1) begin
            miscompares++;
            $display("FAIL ign_midmove got=%b/%0d exp=1/1", moving, out_current_floor);
        end
        reset = 1'b0; req_valid = 1'b1; req_floor = 4'd4;
        tick();
        reset = 1'b1; req_valid = 1'b0;
        vectors++;
        if (obs() !== RST_VEC) begin
            miscompares++;
            $display("FAIL ign_reset_move got=%h exp=%h", obs(), RST_VEC);
        end
        tick();
        vectors++;
        if (obs() !== exp_vec() || pending !== 8'h00) begin
            miscompares++;
            $display("FAIL ign_post_reset got=%h exp=%h", obs(), exp_vec());
        end
    endtask

    task automatic test_back_to_back();
        int calls[$] = '{7, 1, 4, 6};
        int want[$];
        int served[$];
        bit bad = 1'b0;
        do_reset();
        foreach (calls[k]) begin
            req_valid = 1'b1; req_floor = 4'(calls[k]);
            tick();
        end
        req_valid = 1'b0;
        want = calls;
        want.sort();
        for (int i = 0; i < 80; i++) begin
            tick();
            vectors++;
            if (obs() !== exp_vec()) begin
                miscompares++;
                $display("FAIL b2b_model cyc=%0d got=%h exp=%h", i, obs(), exp_vec());
            end
            if (complete) served.push_back(int'(out_current_floor));
        end
        if (served.size() != want.size()) bad = 1'b1;
        else foreach (want[k]) if (served[k] != want[k]) bad = 1'b1;
        vectors++;
        if (bad) begin
            miscompares++;
            $display("FAIL b2b_order got=%p exp=%p", served, want);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 2500; i++) begin
            reset            = ($urandom_range(0, 999) != 0);
            req_valid        = ($urandom_range(0, 5) == 0);
            req_floor        = 4'($urandom_range(0, 9));
            pos_load         = ($urandom_range(0, 49) == 0);
            in_current_floor = 4'($urandom_range(0, 9));
            over_time        = ($urandom_range(0, 19) == 0);
            over_weight      = ($urandom_range(0, 24) == 0);
            tick();
            vectors++;
            if (obs() !== exp_vec()) begin
                miscompares++;
                $display("FAIL rand_model cyc=%0d got=%h exp=%h", i, obs(), exp_vec());
            end
        end
        reset = 1'b1;
        idle_inputs();
        for (int i = 0; i < 300; i++) begin
            tick();
            vectors++;
            if (obs() !== exp_vec()) begin
                miscompares++;
                $display("FAIL drain_model cyc=%0d got=%h exp=%h", i, obs(), exp_vec());
            end
        end
        vectors++;
        if (pending !== 8'h00 || moving !== 1'b0 || door_open !== 1'b0) begin
            miscompares++;
            $display("FAIL drain_idle got=%h/%b/%b exp=00/0/0", pending, moving, door_open);
        end
    endtask

    initial begin
        reset            = 1'b0;
        req_floor        = '0;
        in_current_floor = '0;
        idle_inputs();
        test_reset();
        test_single_call();
        test_scan();
        test_door_overtime();
        test_overweight();
        test_ignored();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
